// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder: FSM state enum,
// instruction width and the bit positions of the captured {N,V,Z} flags.
package instr_feeder_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_CAPTURE   = 3'd5
    } feeder_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue for instr_feeder: DEPTH-entry FIFO with a combinational
// head; a push while full is accepted only when a pop happens in the same cycle.
module instr_fifo
    import instr_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Feeds queued instructions to a CPU one at a time and captures each result.
// Optional FEEDER_TIMEOUT_EN adds a bounded wait on cpu_w with a sticky error.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               go,
    output logic               full,
    output logic               empty,
    output logic [INSTR_W-1:0] cpu_in,
    output logic               cpu_load,
    output logic               cpu_s,
    input  logic [INSTR_W-1:0] cpu_out,
    input  logic               cpu_n,
    input  logic               cpu_v,
    input  logic               cpu_z,
    input  logic               cpu_w,
    output logic               res_valid,
    output logic [INSTR_W-1:0] res_data,
    output logic [2:0]         res_nvz,
    output logic [7:0]         done_count,
    output logic               busy,
    output logic               timeout_err
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("instr_feeder: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("instr_feeder: TIMEOUT must be at least 1");
    end

    feeder_state_t      state;
    feeder_state_t      state_next;
    logic [INSTR_W-1:0] fifo_head;
    logic               issue;
    logic               wait_expired;
    logic               capture;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .pop     (cpu_load),
        .wr_data (wr_data),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (empty)
    );

    assign issue   = (state == ST_IDLE) && go && !empty && !timeout_err;
    assign capture = (state == ST_WAIT_DONE) && cpu_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_load   = 1'b0;
        cpu_s      = 1'b0;
        busy       = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (issue) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cpu_load   = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                cpu_s      = 1'b1;
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!cpu_w) begin
                    state_next = ST_WAIT_DONE;
                end else if (wait_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (cpu_w) begin
                    state_next = ST_CAPTURE;
                end else if (wait_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // cpu_in is latched as the FSM enters LOAD, so it already shows the
    // queue head during LOAD and keeps the word after the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_in <= '0;
        end else if (issue) begin
            cpu_in <= fifo_head;
        end
    end

    // Results are registered on the WAIT_DONE->CAPTURE edge, so res_valid
    // and the captured data are visible during the CAPTURE cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_nvz    <= '0;
            done_count <= '0;
        end else begin
            res_valid <= capture;
            if (capture) begin
                res_data        <= cpu_out;
                res_nvz[FLAG_N] <= cpu_n;
                res_nvz[FLAG_V] <= cpu_v;
                res_nvz[FLAG_Z] <= cpu_z;
                done_count      <= done_count + 8'd1;
            end
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;
    logic          in_wait;

    assign in_wait     = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
    assign timeout_err = timeout_q;

    always_comb begin
        wait_expired = 1'b0;
        if (wait_cnt == CW'(TIMEOUT - 1)) begin
            wait_expired = ((state == ST_WAIT_BUSY) && cpu_w) ||
                           ((state == ST_WAIT_DONE) && !cpu_w);
        end
    end

    // Counts cycles spent in the current wait state; restarts on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_wait && (state_next == state)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (wait_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: directed steps plus random traffic,
// checked against a queue-based reference model and a behavioural CPU model.
module tb_instr_feeder;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        go;
    logic        full;
    logic        empty;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic [15:0] cpu_out;
    logic        cpu_n;
    logic        cpu_v;
    logic        cpu_z;
    logic        cpu_w;
    logic        res_valid;
    logic [15:0] res_data;
    logic [2:0]  res_nvz;
    logic [7:0]  done_count;
    logic        busy;
    logic        timeout_err;

    instr_feeder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .go          (go),
        .full        (full),
        .empty       (empty),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .cpu_s       (cpu_s),
        .cpu_out     (cpu_out),
        .cpu_n       (cpu_n),
        .cpu_v       (cpu_v),
        .cpu_z       (cpu_z),
        .cpu_w       (cpu_w),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_nvz     (res_nvz),
        .done_count  (done_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural CPU: result is the low 12 bits; N=bit15, V=bit14&bit13, Z=(result==0).
    function automatic logic [15:0] ref_out(input logic [15:0] w);
        return {4'h0, w[11:0]};
    endfunction

    function automatic logic [2:0] ref_nvz(input logic [15:0] w);
        return {w[15], w[14] & w[13], (w[11:0] == 12'h000)};
    endfunction

    // Reference model state (cleared whenever reset is seen low).
    logic [15:0] mq[$];
    logic [15:0] issued[$];
    int          load_cyc[$];
    int          len_q[$];
    logic [15:0] res_log[$];
    int          cyc = 0;
    int          total = 0;
    int          accepted = 0;
    int          pulses = 0;
    int          last_s_cyc = 0;
    logic        prev_load = 1'b0;
    logic [15:0] last_load_word = '0;
    int          mon_sz;
    logic [15:0] mon_w;
    int          mon_lc;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset !== 1'b1) begin
                mq.delete();
                issued.delete();
                load_cyc.delete();
                len_q.delete();
                total     = 0;
                accepted  = 0;
                prev_load = 1'b0;
            end else begin
                mon_sz = mq.size();
                if (prev_load && mon_sz > 0) void'(mq.pop_front());
                if (wr_en === 1'b1 && (mon_sz < int'(DEPTH) || prev_load)) begin
                    mq.push_back(wr_data);
                    accepted++;
                end
                check("full", full, mq.size() == int'(DEPTH));
                check("empty", empty, mq.size() == 0);
                check("load_s_exclusive", cpu_load & cpu_s, 0);
                if (cpu_load === 1'b1) begin
                    last_load_word = cpu_in;
                    check("load_nonempty", mq.size() != 0, 1);
                    if (mq.size() != 0) begin
                        check("load_cpu_in", cpu_in, mq[0]);
                        issued.push_back(mq[0]);
                        load_cyc.push_back(cyc);
                    end
                end
                if (cpu_s === 1'b1) begin
                    last_s_cyc = cyc;
                    if (issued.size() != 0) check("start_cpu_in", cpu_in, issued[$]);
                end
                if (res_valid === 1'b1) begin
                    pulses++;
                    res_log.push_back(res_data);
                    if (issued.size() == 0) begin
                        check("res_unexpected", res_valid, 0);
                    end else begin
                        mon_w  = issued.pop_front();
                        mon_lc = load_cyc.pop_front();
                        total++;
                        check("res_data", res_data, ref_out(mon_w));
                        check("res_nvz", res_nvz, ref_nvz(mon_w));
                        check("done_count", done_count, total % 256);
                        if (len_q.size() != 0) check("latency", cyc - mon_lc, len_q.pop_front() + 3);
                    end
                end
                prev_load = cpu_load;
            end
        end
    end

    // CPU model: drops cpu_w one cycle after cpu_s and holds it low for len cycles.
    int          busy_len_cfg = 0;
    logic        cpu_hang = 1'b0;
    logic [15:0] cpu_word;
    int          cpu_len;

    initial begin
        cpu_w   = 1'b1;
        cpu_out = '0;
        cpu_n   = 1'b0;
        cpu_v   = 1'b0;
        cpu_z   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1 && cpu_s === 1'b1) begin
                cpu_word = cpu_in;
                cpu_len  = (busy_len_cfg > 0) ? busy_len_cfg : int'($urandom_range(1, 4));
                @(posedge clk);
                #1;
                if (reset === 1'b1) begin
                    cpu_out = ref_out(cpu_word);
                    {cpu_n, cpu_v, cpu_z} = ref_nvz(cpu_word);
                    cpu_w = 1'b0;
                    if (cpu_hang) begin
                        while (cpu_hang && reset === 1'b1) begin
                            @(posedge clk);
                            #1;
                        end
                    end else begin
                        len_q.push_back(cpu_len);
                        for (int i = 0; i < cpu_len && reset === 1'b1; i++) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                cpu_w = 1'b1;
            end
        end
    end

    task automatic push_word(input logic [15:0] w);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n = 0;
        while (pulses < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, pulses >= target, 1);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (!(mq.size() == 0 && issued.size() == 0 && busy === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, (mq.size() == 0 && issued.size() == 0), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_in"}, cpu_in, 0);
        check({tag, "_cpu_load"}, cpu_load, 0);
        check({tag, "_cpu_s"}, cpu_s, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_nvz"}, res_nvz, 0);
        check({tag, "_done_count"}, done_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
    endtask

    logic [15:0] words8[8];
    int          p0;
    int          base;
    int          n;
    int          elapsed;
    logic        saw_busy;

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        go      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Single instruction with a 4-cycle CPU busy window.
        busy_len_cfg = 4;
        push_word(16'hD003);
        go = 1'b1;
        wait_pulses(1, 60, "single");
        @(negedge clk);
        check("single_cpu_in", last_load_word, 16'hD003);
        check("single_res_data", res_data, 16'h0003);
        check("single_done", done_count, 1);

        // Fill with go low, drop a 9th push, then drain in push order.
        go = 1'b0;
        busy_len_cfg = 0;
        for (int i = 0; i < 8; i++) begin
            words8[i] = 16'($urandom);
            push_word(words8[i]);
        end
        check("fill_full", full, 1);
        check("fill_busy", busy, 0);
        push_word(16'h5A5A);
        check("ninth_full", full, 1);
        base = pulses;
        go = 1'b1;
        wait_pulses(base + 8, 300, "fill");
        repeat (20) @(negedge clk);
        check("fill_pulses", pulses - base, 8);
        check("fill_empty", empty, 1);
        for (int i = 0; i < 8; i++) begin
            check("fill_order", res_log[base + i], ref_out(words8[i]));
        end

        // Flag capture.
        push_word(16'hA805);
        wait_pulses(pulses + 1, 60, "flags");
        @(negedge clk);
        check("flags_nvz", res_nvz, 3'b100);
        check("flags_data", res_data, 16'h0805);

        // go falls mid-instruction: current one completes, the next waits.
        go = 1'b0;
        @(negedge clk);
        base = pulses;
        push_word(16'h1111);
        push_word(16'h2222);
        go = 1'b1;
        n = 0;
        while (cpu_s !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        go = 1'b0;
        wait_pulses(base + 1, 60, "gofall");
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        check("gofall_hold_idle", saw_busy, 0);
        check("gofall_pulses", pulses - base, 1);
        check("gofall_pending", empty, 0);
        go = 1'b1;
        wait_drain(100, "gofall");

        // Keep the queue full while it drains: push and pop coincide when full.
        go = 1'b0;
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        check("swap_full", full, 1);
        go = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 16'($urandom);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain(600, "swap");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_data = 16'($urandom);
            go      = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk);
        wr_en = 1'b0;
        go    = 1'b1;
        wait_drain(800, "random");

        // Reset during WAIT_DONE aborts the instruction and empties the queue.
        cpu_hang = 1'b1;
        push_word(16'h3C3C);
        push_word(16'h4D4D);
        n = 0;
        while (cpu_w !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("abort_cpu_busy", cpu_w, 0);
        repeat (2) @(negedge clk);
        p0 = pulses;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        cpu_hang = 1'b0;
        go       = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_pulse", pulses, p0);
        check("abort_done", done_count, 0);
        check("abort_busy", busy, 0);

        // CPU that never finishes.
        cpu_hang = 1'b1;
        p0 = pulses;
        go = 1'b1;
        push_word(16'h7E01);
`ifdef FEEDER_TIMEOUT_EN
        n = 0;
        while (timeout_err !== 1'b1 && n < int'(TIMEOUT) + 40) begin
            @(negedge clk);
            n++;
        end
        elapsed = cyc - last_s_cyc;
        check("timeout_set", timeout_err, 1);
        check("timeout_window", (elapsed >= int'(TIMEOUT) && elapsed <= int'(TIMEOUT) + 4), 1);
        check("timeout_busy", busy, 0);
        check("timeout_no_pulse", pulses, p0);
        push_word(16'h7E02);
        saw_busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        check("timeout_stays_idle", saw_busy, 0);
        check("timeout_sticky", timeout_err, 1);
`else
        repeat (int'(TIMEOUT) + 40) @(negedge clk);
        check("hang_no_timeout", timeout_err, 0);
        check("hang_still_busy", busy, 1);
        check("hang_no_pulse", pulses, p0);
`endif
        go = 1'b0;
        reset = 1'b0;
        cpu_hang = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_hang_timeout_err", timeout_err, 0);

        // 256 completions wrap done_count back to zero.
        busy_len_cfg = 1;
        go = 1'b1;
        n = 0;
        while (accepted < 256 && n < 6000) begin
            @(negedge clk);
            wr_en   = (accepted < 256);
            wr_data = 16'($urandom);
            n++;
        end
        wr_en = 1'b0;
        wait_drain(3000, "wrap");
        @(negedge clk);
        check("wrap_total", total, 256);
        check("wrap_done_count", done_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
